// File: rtl/path_stack.sv
// rtl/path_stack.sv - DFS location stack with oldest-first path replay port
module path_stack #(
  parameter int LOC_W = 8,
  parameter int DEPTH = 256,
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [LOC_W-1:0] din,
  output logic [LOC_W-1:0] top,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf,
  input  logic             play_start,
  output logic             play_valid,
  input  logic             play_ready,
  output logic [LOC_W-1:0] play_loc,
  output logic             play_done,
  output logic             busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {LIFO = 2'd0, PLAY = 2'd1, FIN = 2'd2} stateE;

  stateE            state;
  stateE            nextState;
  logic [CNT_W-1:0] sp;
  logic [CNT_W-1:0] rdIdx;
  logic             ovfReg;
  logic             unfReg;
  logic [LOC_W-1:0] mem [DEPTH];

  logic [AW-1:0]    topAddr;
  logic [AW-1:0]    wrAddr;
  logic [AW-1:0]    rdAddr;
  logic             stackOp;
  logic             doPush;
  logic             doPop;
  logic             doReplace;
  logic             doOvf;
  logic             doUnf;
  logic             accept;

  assign topAddr = AW'(sp - CNT_W'(1));
  assign rdAddr  = AW'(rdIdx);

  assign empty = (sp == '0);
  assign full  = (sp == CNT_W'(DEPTH));
  assign top   = empty ? '0 : mem[topAddr];
  assign ovf   = ovfReg;
  assign unf   = unfReg;

  // push/pop only act in LIFO; a replay request or clear masks them that cycle
  assign stackOp   = (state == LIFO) && !clr && !play_start;
  assign doReplace = stackOp && push && pop && !empty;
  assign doPush    = stackOp && push && (!pop || empty) && !full;
  assign doOvf     = stackOp && push && !pop && full;
  assign doPop     = stackOp && pop && !push && !empty;
  assign doUnf     = stackOp && pop && !push && empty;
  assign accept    = play_valid && play_ready;

  assign wrAddr   = doReplace ? topAddr : AW'(sp);
  assign play_loc = play_valid ? mem[rdAddr] : '0;

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= LIFO;
    end else begin
      state <= nextState;
    end
  end

  // next-state: LIFO -> PLAY on request, PLAY -> FIN once every entry is read
  always_comb begin
    nextState = state;
    case (state)
      LIFO:    if (play_start) nextState = PLAY;
      PLAY:    if (!(rdIdx < sp)) nextState = FIN;
      FIN:     nextState = LIFO;
      default: nextState = LIFO;
    endcase
    if (clr) nextState = LIFO;
  end

  // FSM outputs: replay handshake, completion pulse and busy
  always_comb begin
    play_valid = 1'b0;
    play_done  = 1'b0;
    busy       = (state != LIFO);
    case (state)
      PLAY:    play_valid = (rdIdx < sp);
      FIN:     play_done  = 1'b1;
      default: ;
    endcase
  end

  // stack pointer, replay index and sticky error flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp     <= '0;
      rdIdx  <= '0;
      ovfReg <= 1'b0;
      unfReg <= 1'b0;
    end else if (clr) begin
      sp     <= '0;
      rdIdx  <= '0;
      ovfReg <= 1'b0;
      unfReg <= 1'b0;
    end else if (state == FIN) begin
      // the replayed path is consumed
      sp    <= '0;
      rdIdx <= '0;
    end else begin
      if (doPush)      sp <= sp + CNT_W'(1);
      else if (doPop)  sp <= sp - CNT_W'(1);
      if (state == LIFO && play_start) rdIdx <= '0;
      else if (accept)                 rdIdx <= rdIdx + CNT_W'(1);
      if (doOvf) ovfReg <= 1'b1;
      if (doUnf) unfReg <= 1'b1;
    end
  end

  // location storage; contents survive pops and are not reset
  always_ff @(posedge clk) begin
    if (doPush || doReplace) mem[wrAddr] <= din;
  end

endmodule

// File: tb/tb_path_stack.sv
// tb/tb_path_stack.sv - self-checking bench for path_stack
module tb_path_stack;

  localparam int LOC_W = 8;
  localparam int DEPTH = 256;
  localparam int CNT_W = 9;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             clr = 1'b0;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic [LOC_W-1:0] din = '0;
  logic [LOC_W-1:0] top;
  logic             empty;
  logic             full;
  logic             ovf;
  logic             unf;
  logic             play_start = 1'b0;
  logic             play_valid;
  logic             play_ready = 1'b0;
  logic [LOC_W-1:0] play_loc;
  logic             play_done;
  logic             busy;

  int testsRun = 0;
  int testsFailed = 0;
  logic [LOC_W-1:0] expQ[$];

  path_stack #(.LOC_W(LOC_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .clr(clr), .push(push), .pop(pop), .din(din),
    .top(top), .empty(empty), .full(full), .ovf(ovf), .unf(unf),
    .play_start(play_start), .play_valid(play_valid), .play_ready(play_ready),
    .play_loc(play_loc), .play_done(play_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doPush(input logic [LOC_W-1:0] v);
    push = 1'b1; din = v;
    step();
    push = 1'b0;
  endtask

  task automatic doPop();
    pop = 1'b1;
    step();
    pop = 1'b0;
  endtask

  task automatic doClear();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    testsRun++;
    if (top !== 8'h00 || empty !== 1'b1 || full !== 1'b0 || ovf !== 1'b0 || unf !== 1'b0) begin
      testsFailed++;
      $display("FAIL reset_stack: top=%h empty=%b full=%b ovf=%b unf=%b, want 00 1 0 0 0", top, empty, full, ovf, unf);
    end
    testsRun++;
    if (play_valid !== 1'b0 || play_done !== 1'b0 || busy !== 1'b0) begin
      testsFailed++;
      $display("FAIL reset_play: valid=%b done=%b busy=%b, want 0 0 0", play_valid, play_done, busy);
    end
  endtask

  task automatic test_push_pop();
    doPush(8'h00); doPush(8'h01); doPush(8'h11);
    testsRun++;
    if (dut.sp !== 9'd3 || top !== 8'h11 || empty !== 1'b0) begin
      testsFailed++;
      $display("FAIL push3: sp=%0d top=%h empty=%b, want 3 11 0", dut.sp, top, empty);
    end
    doPop();
    testsRun++;
    if (top !== 8'h01 || dut.sp !== 9'd2) begin
      testsFailed++;
      $display("FAIL pop: top=%h sp=%0d, want 01 2", top, dut.sp);
    end
    doClear();
  endtask

  task automatic test_flags();
    doPop();
    testsRun++;
    if (unf !== 1'b1 || dut.sp !== 9'd0 || top !== 8'h00) begin
      testsFailed++;
      $display("FAIL underflow: unf=%b sp=%0d top=%h, want 1 0 00", unf, dut.sp, top);
    end
    doClear();
    testsRun++;
    if (unf !== 1'b0) begin
      testsFailed++;
      $display("FAIL clr_unf: unf=%b, want 0", unf);
    end
    for (int i = 0; i < DEPTH; i++) doPush(LOC_W'(i) ^ 8'h5A);
    testsRun++;
    if (full !== 1'b1 || ovf !== 1'b0 || top !== 8'hA5) begin
      testsFailed++;
      $display("FAIL fill: full=%b ovf=%b top=%h, want 1 0 a5", full, ovf, top);
    end
    doPush(8'hAA);
    testsRun++;
    if (full !== 1'b1 || ovf !== 1'b1 || top !== 8'hA5 || dut.sp !== 9'd256) begin
      testsFailed++;
      $display("FAIL overflow: full=%b ovf=%b top=%h sp=%0d, want 1 1 a5 256", full, ovf, top, dut.sp);
    end
    doClear();
  endtask

  task automatic test_replace();
    doPush(8'h04); doPush(8'h05);
    push = 1'b1; pop = 1'b1; din = 8'h37;
    step();
    push = 1'b0; pop = 1'b0;
    testsRun++;
    if (dut.sp !== 9'd2 || top !== 8'h37) begin
      testsFailed++;
      $display("FAIL replace_top: sp=%0d top=%h, want 2 37", dut.sp, top);
    end
    doPop();
    testsRun++;
    if (top !== 8'h04) begin
      testsFailed++;
      $display("FAIL replace_below: top=%h, want 04", top);
    end
    doClear();
    push = 1'b1; pop = 1'b1; din = 8'h09;
    step();
    push = 1'b0; pop = 1'b0;
    testsRun++;
    if (dut.sp !== 9'd1 || top !== 8'h09 || unf !== 1'b0) begin
      testsFailed++;
      $display("FAIL replace_empty: sp=%0d top=%h unf=%b, want 1 09 0", dut.sp, top, unf);
    end
    doClear();
  endtask

  task automatic test_replay();
    logic [LOC_W-1:0] vals [4] = '{8'h00, 8'h10, 8'h11, 8'hFF};
    logic readyPat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [LOC_W-1:0] heldLoc;
    logic [LOC_W-1:0] want;
    logic heldPending;
    int accepted;
    int k;
    int doneCycles;
    expQ.delete();
    for (int i = 0; i < 4; i++) begin
      doPush(vals[i]);
      expQ.push_back(vals[i]);
    end
    play_start = 1'b1; push = 1'b1; din = 8'h77;
    step();
    play_start = 1'b0; push = 1'b0;
    testsRun++;
    if (busy !== 1'b1 || play_valid !== 1'b1 || dut.sp !== 9'd4) begin
      testsFailed++;
      $display("FAIL play_enter: busy=%b valid=%b sp=%0d, want 1 1 4", busy, play_valid, dut.sp);
    end
    accepted = 0; k = 0; heldPending = 1'b0;
    while (expQ.size() > 0 && k < 20) begin
      play_ready = readyPat[k % 5];
      #1;
      if (heldPending) begin
        testsRun++;
        if (play_loc !== heldLoc || play_valid !== 1'b1) begin
          testsFailed++;
          $display("FAIL play_hold: loc=%h valid=%b, want %h 1", play_loc, play_valid, heldLoc);
        end
        heldPending = 1'b0;
      end
      if (play_valid && play_ready) begin
        want = expQ.pop_front();
        accepted++;
        testsRun++;
        if (play_loc !== want) begin
          testsFailed++;
          $display("FAIL play_order: loc=%h, want %h", play_loc, want);
        end
      end else if (play_valid) begin
        heldLoc = play_loc;
        heldPending = 1'b1;
      end
      step();
      k++;
    end
    play_ready = 1'b0;
    testsRun++;
    if (accepted !== 4 || k !== 5) begin
      testsFailed++;
      $display("FAIL play_count: accepted=%0d cycles=%0d, want 4 5", accepted, k);
    end
    testsRun++;
    if (play_valid !== 1'b0 || play_loc !== 8'h00 || play_done !== 1'b0) begin
      testsFailed++;
      $display("FAIL play_drain: valid=%b loc=%h done=%b, want 0 00 0", play_valid, play_loc, play_done);
    end
    k = 0;
    while (play_done !== 1'b1 && k < 8) begin
      step();
      k++;
    end
    testsRun++;
    if (play_done !== 1'b1 || k !== 1) begin
      testsFailed++;
      $display("FAIL play_done_latency: done=%b cycles=%0d, want 1 1", play_done, k);
    end
    doneCycles = 0;
    while (play_done === 1'b1 && doneCycles < 8) begin
      step();
      doneCycles++;
    end
    testsRun++;
    if (doneCycles !== 1 || empty !== 1'b1 || busy !== 1'b0) begin
      testsFailed++;
      $display("FAIL play_finish: pulse=%0d empty=%b busy=%b, want 1 1 0", doneCycles, empty, busy);
    end
  endtask

  task automatic test_empty_replay();
    play_start = 1'b1;
    step();
    play_start = 1'b0;
    testsRun++;
    if (busy !== 1'b1 || play_valid !== 1'b0 || play_done !== 1'b0) begin
      testsFailed++;
      $display("FAIL empty_play1: busy=%b valid=%b done=%b, want 1 0 0", busy, play_valid, play_done);
    end
    step();
    testsRun++;
    if (play_done !== 1'b1 || play_valid !== 1'b0) begin
      testsFailed++;
      $display("FAIL empty_play2: done=%b valid=%b, want 1 0", play_done, play_valid);
    end
    step();
    testsRun++;
    if (play_done !== 1'b0 || busy !== 1'b0 || empty !== 1'b1) begin
      testsFailed++;
      $display("FAIL empty_play3: done=%b busy=%b empty=%b, want 0 0 1", play_done, busy, empty);
    end
  endtask

  task automatic test_reset_clr_midplay();
    doPush(8'h21); doPush(8'h22); doPush(8'h23);
    play_start = 1'b1;
    step();
    play_start = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    testsRun++;
    if (play_valid !== 1'b0 || dut.sp !== 9'd0 || busy !== 1'b0 || empty !== 1'b1) begin
      testsFailed++;
      $display("FAIL async_rst: valid=%b sp=%0d busy=%b empty=%b, want 0 0 0 1", play_valid, dut.sp, busy, empty);
    end
    step();
    rst = 1'b1;
    doPop();
    doPush(8'h31); doPush(8'h32);
    play_start = 1'b1;
    step();
    play_start = 1'b0;
    testsRun++;
    if (busy !== 1'b1 || unf !== 1'b1 || play_valid !== 1'b1 || play_loc !== 8'h31) begin
      testsFailed++;
      $display("FAIL clr_setup: busy=%b unf=%b valid=%b loc=%h, want 1 1 1 31", busy, unf, play_valid, play_loc);
    end
    doClear();
    testsRun++;
    if (busy !== 1'b0 || unf !== 1'b0 || ovf !== 1'b0 || empty !== 1'b1 || play_valid !== 1'b0) begin
      testsFailed++;
      $display("FAIL clr_midplay: busy=%b unf=%b ovf=%b empty=%b valid=%b, want 0 0 0 1 0", busy, unf, ovf, empty, play_valid);
    end
  endtask

  initial begin
    rst = 1'b0;
    step();
    step();
    test_reset();
    rst = 1'b1;
    step();
    test_push_pop();
    test_flags();
    test_replace();
    test_replay();
    test_empty_replay();
    test_reset_clr_midplay();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
